// File: rtl/ring_fifo.sv
// ring_fifo: circular FIFO with same-cycle read/write, level flags, sticky error reporting and flush
module ring_fifo #(
    parameter int WordSize = 8,
    parameter int LengthBits = 3,
    localparam int BufferLength = 1 << LengthBits,
    parameter int AlmostFullLevel = BufferLength - 1,
    parameter int AlmostEmptyLevel = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  dataWriteEnable,
    input  logic [WordSize-1:0]   dataWrite,
    output logic                  dataWriteAck,
    input  logic                  dataReadEnable,
    output logic                  dataReadAck,
    output logic [WordSize-1:0]   dataRead,
    output logic [LengthBits:0]   bufferLength,
    output logic                  full,
    output logic                  empty,
    output logic                  almostFull,
    output logic                  almostEmpty,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clearErrors,
    output logic [15:0]           dropCount
);
    localparam logic [LengthBits:0] depth = {1'b1, {LengthBits{1'b0}}};
    localparam logic [LengthBits:0] af_lvl = AlmostFullLevel[LengthBits:0];
    localparam logic [LengthBits:0] ae_lvl = AlmostEmptyLevel[LengthBits:0];
    logic [WordSize-1:0] mem [BufferLength];
    logic [LengthBits-1:0] rd_ptr, wr_ptr;
    logic [LengthBits:0] count;
    logic rd, wr, wr_rej, rd_rej;
    // a write into a full FIFO is still accepted when a read frees a slot in the same cycle
    always_comb begin
        rd = dataReadEnable && count != '0;
        wr = dataWriteEnable && (count != depth || rd);
        wr_rej = dataWriteEnable && !wr;
        rd_rej = dataReadEnable && !rd;
        bufferLength = count;
        full = count == depth;
        empty = count == '0;
        almostFull = count >= af_lvl;
        almostEmpty = count <= ae_lvl;
    end
    // storage is not reset; writes land only on accepted, non-flushed cycles
    always_ff @(posedge clk)
        if (reset && !flush && wr) mem[wr_ptr] <= dataWrite;
    // pointers, count, read data, acks and error reporting
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            dataRead <= '0;
            dataReadAck <= 1'b0;
            dataWriteAck <= 1'b0;
            overflow <= 1'b0;
            underflow <= 1'b0;
            dropCount <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            dataReadAck <= 1'b0;
            dataWriteAck <= 1'b0;
        end else begin
            dataReadAck <= rd;
            dataWriteAck <= wr;
            if (rd) begin
                dataRead <= mem[rd_ptr];
                rd_ptr <= rd_ptr + LengthBits'(1);
            end
            if (wr) wr_ptr <= wr_ptr + LengthBits'(1);
            count <= (wr && !rd) ? count + (LengthBits+1)'(1) :
                     (rd && !wr) ? count - (LengthBits+1)'(1) : count;
            overflow <= wr_rej || (overflow && !clearErrors);
            underflow <= rd_rej || (underflow && !clearErrors);
            dropCount <= clearErrors ? {15'd0, wr_rej} :
                         (wr_rej && dropCount != 16'hFFFF) ? dropCount + 16'd1 : dropCount;
        end
    end
endmodule
